// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
//
// Registered result stage behind the 32-bit ALU. Each accepted ALU result is
// stored with its destination tag and status flags {cout,o,n,z} in a small
// FIFO. The FIFO head is offered to writeback/branch logic over valid/ready.
// The block also keeps the flags of the last popped entry (cflags) and a
// sticky overflow bit for the control unit.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = !full && !rst)
//   in_result, in_tag     ALU result and destination tag
//   in_cout/o/n/z         ALU status flags
//   out_valid / out_ready downstream handshake (out_valid = non-empty)
//   out_result/tag/flags  head entry, forced to 0 when empty
//   count                 occupancy, 0..DEPTH
//   cflags                flags {cout,o,n,z} of the most recently popped entry
//   sticky_o              set by any accepted entry with o=1
//   clr_sticky            clears sticky_o (a coincident o=1 push wins)
// ---------------------------------------------------------------------------
module alu_result_queue #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_cout,
    input  logic                       in_o,
    input  logic                       in_n,
    input  logic                       in_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic [3:0]                 cflags,
    output logic                       sticky_o,
    input  logic                       clr_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag;
        logic [3:0]        flags;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         cflags_q, cflags_d;
    logic               sticky_q, sticky_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    entry_t             head;
    entry_t             wr_entry;

    // Handshake status comes only from registered occupancy (plus rst), so
    // there is no path from in_valid to out_valid or out_ready to in_ready.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full && !rst;
    assign out_valid = !empty && !rst;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign head     = mem_q[rptr_q];
    assign wr_entry = '{result: in_result, tag: in_tag,
                        flags: {in_cout, in_o, in_n, in_z}};

    // Storage contents are never reset; the gating below keeps the outputs
    // deterministic while the queue is empty or in reset.
    assign out_result = out_valid ? head.result : '0;
    assign out_tag    = out_valid ? head.tag    : '0;
    assign out_flags  = out_valid ? head.flags  : '0;

    assign count    = count_q;
    assign cflags   = cflags_q;
    assign sticky_o = sticky_q;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        cflags_d = cflags_q;
        sticky_d = sticky_q;

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d   = rptr_q + PTR_W'(1);
            cflags_d = head.flags;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        if (push && in_o) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            cflags_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            cflags_q <= cflags_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_result_queue
//
// Directed bench for alu_result_queue. Inputs change 1 ns after a rising
// edge; outputs are checked 1 ns after that, well before the next edge.
// ---------------------------------------------------------------------------
module tb_alu_result_queue;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [TAG_W-1:0]  in_tag;
    logic              in_cout, in_o, in_n, in_z;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_flags;
    logic [2:0]        count;
    logic [3:0]        cflags;
    logic              sticky_o;
    logic              clr_sticky;

    int n_cmp = 0;
    int n_err = 0;

    alu_result_queue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_tag     (in_tag),
        .in_cout    (in_cout),
        .in_o       (in_o),
        .in_n       (in_n),
        .in_z       (in_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .count      (count),
        .cflags     (cflags),
        .sticky_o   (sticky_o),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] r, input logic [4:0] t,
                          input logic [3:0] f);
        in_valid  = v;
        in_result = r;
        in_tag    = t;
        {in_cout, in_o, in_n, in_z} = f;
    endtask

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        set_in(1'b1, 32'h11, 5'd1, 4'b0100);

        // Reset held for two edges with in_valid=1
        tick(); #1;
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count), 64'd0);
        chk("rst_sticky",    64'(sticky_o), 64'd0);
        chk("rst_cflags",    64'(cflags), 64'd0);
        chk("rst_out_result",64'(out_result), 64'd0);
        tick(); #1;
        chk("rst2_in_ready", 64'(in_ready), 64'd0);
        chk("rst2_count",    64'(count), 64'd0);
        chk("rst2_sticky",   64'(sticky_o), 64'd0);

        rst = 1'b0;
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("post_rst_in_ready",  64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Single pass
        set_in(1'b1, 32'h0000_0005, 5'd3, 4'b0000);
        tick();
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("sp_out_valid", 64'(out_valid), 64'd1);
        chk("sp_out_result",64'(out_result), 64'd5);
        chk("sp_out_tag",   64'(out_tag), 64'd3);
        chk("sp_count",     64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("sp_pop_out_valid", 64'(out_valid), 64'd0);
        chk("sp_pop_count",     64'(count), 64'd0);
        chk("sp_pop_cflags",    64'(cflags), 64'd0);
        chk("sp_empty_result",  64'(out_result), 64'd0);

        // Fill and wrap
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'hA0 + 32'(i), 5'(i), 4'b0000);
            tick();
        end
        set_in(1'b1, 32'hA4, 5'd4, 4'b0000);
        #1;
        chk("full_count",    64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("full_drop_count", 64'(count), 64'd4);
        chk("full_head",       64'(out_result), 64'hA0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        chk("pop2_count", 64'(count), 64'd2);
        chk("pop2_head",  64'(out_result), 64'hA2);
        set_in(1'b1, 32'hB0, 5'd10, 4'b0000);
        tick();
        set_in(1'b1, 32'hB1, 5'd11, 4'b0000);
        tick();
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("refill_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        begin
            logic [31:0] exp_drain [4];
            exp_drain = '{32'hA2, 32'hA3, 32'hB0, 32'hB1};
            for (int i = 0; i < 4; i++) begin
                #1;
                chk($sformatf("drain_%0d", i), 64'(out_result), 64'(exp_drain[i]));
                tick();
            end
        end
        out_ready = 1'b0;
        #1;
        chk("drain_empty", 64'(count), 64'd0);

        // Simultaneous push/pop at count=2
        set_in(1'b1, 32'hC0, 5'd0, 4'b0000);
        tick();
        set_in(1'b1, 32'hC1, 5'd1, 4'b0000);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 32'hC2 + 32'(k), 5'(k + 2), 4'b0000);
            #1;
            chk($sformatf("pp_count_%0d", k), 64'(count), 64'd2);
            chk($sformatf("pp_head_%0d", k),  64'(out_result), 64'hC0 + 64'(k));
            chk($sformatf("pp_tag_%0d", k),   64'(out_tag), 64'(k));
            tick();
        end
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("pp_end_count", 64'(count), 64'd2);
        chk("pp_end_head5", 64'(out_result), 64'hC5);
        tick(); #1;
        chk("pp_end_head6", 64'(out_result), 64'hC6);
        tick();
        out_ready = 1'b0;
        #1;
        chk("pp_drained", 64'(count), 64'd0);

        // Flags and sticky overflow
        set_in(1'b1, 32'h8000_0000, 5'd7, 4'b1110);
        tick();
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("fl_sticky_set", 64'(sticky_o), 64'd1);
        chk("fl_out_flags",  64'(out_flags), 64'b1110);
        chk("fl_out_result", 64'(out_result), 64'h8000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("fl_cflags", 64'(cflags), 64'b1110);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        #1;
        chk("fl_sticky_clr", 64'(sticky_o), 64'd0);
        chk("fl_cflags_hold", 64'(cflags), 64'b1110);
        clr_sticky = 1'b1;
        set_in(1'b1, 32'h1, 5'd9, 4'b0100);
        tick();
        clr_sticky = 1'b0;
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("fl_set_wins", 64'(sticky_o), 64'd1);
        chk("fl_count1",   64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("fl_cflags2", 64'(cflags), 64'b0100);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'hD0 + 32'(i), 5'(i), 4'b0000);
            tick();
        end
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("mr_count3", 64'(count), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_count",     64'(count), 64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_in_ready",  64'(in_ready), 64'd1);
        chk("mr_sticky",    64'(sticky_o), 64'd0);
        chk("mr_cflags",    64'(cflags), 64'd0);
        set_in(1'b1, 32'hE0, 5'd5, 4'b0001);
        tick();
        set_in(1'b0, 32'h0, 5'd0, 4'b0000);
        #1;
        chk("mr_new_head",  64'(out_result), 64'hE0);
        chk("mr_new_flags", 64'(out_flags), 64'b0001);
        chk("mr_new_count", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Registered result stage directly downstream of the 32-bit ALU. It captures each ALU result together with its destination tag and its four status flags (carry-out, overflow, negative, zero) into a small FIFO. It presents them to the writeback/branch logic over a valid/ready handshake. It also keeps a committed-flags status register and a sticky overflow bit for the control unit.

## Interface
Parameters:
- DATA_W, 32, width of ALU result.
- TAG_W, 5, width of destination-register tag.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  queue can accept; equals !full && !rst.
- in_result  input  DATA_W  ALU result bus.
- in_tag  input  TAG_W  destination register tag.
- in_cout, in_o, in_n, in_z  input  1 each  ALU Cout, overflow, negative, zero flags.
- out_valid  output  1  head entry valid (queue non-empty).
- out_ready  input  1  consumer accepts head.
- out_result  output  DATA_W  head result; 0 when empty.
- out_tag  output  TAG_W  head tag; 0 when empty.
- out_flags  output  4  head flags {cout,o,n,z}; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy.
- cflags  output  4  flags of the most recently popped entry, {cout,o,n,z}.
- sticky_o  output  1  set by any accepted entry with o=1.
- clr_sticky  input  1  clears sticky_o.

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Storage: DEPTH-entry array of {result, tag, cout, o, n, z}. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in count.
- On push: write the entry at wptr and increment wptr.
- On pop: increment rptr and load cflags with the popped entry's flags.
- Simultaneous push and pop when 0 < count < DEPTH: both happen and count is unchanged.
- Full (count==DEPTH): in_ready=0. in_valid is ignored, and input is dropped only if the upstream violates the handshake. A pop in the same cycle does not enable a push; in_ready is a function of registered count only.
- Empty (count==0): out_valid=0. out_ready is ignored. There is no fall-through; data written this cycle is not visible at the output until the next cycle.
- out_* is driven combinationally from the entry at rptr, gated to 0 when count==0.
- sticky_o update:
  - Set on any push with in_o=1.
  - Cleared by clr_sticky.
  - If clr_sticky and a push with in_o=1 coincide, set wins and sticky_o=1.
- cflags holds its value when no pop occurs.
- Storage array contents are not reset. Observable outputs are still deterministic because of the empty gating.

## Timing
- Reset (rst=1 at an edge) sets wptr=rptr=0, count=0, cflags=0 and sticky_o=0.
  - During reset: in_ready=0, out_valid=0, out_result/out_tag/out_flags=0.
  - Reset mid-operation discards all queued entries. The first cycle after rst deasserts shows in_ready=1 and out_valid=0.
- Latency: an entry pushed at edge N appears at out_* with out_valid=1 in the cycle after edge N.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- count, in_ready and out_valid are all derived from registered state. There are no combinational paths from in_valid to out_valid or from out_ready to in_ready.
- Ordering: strict FIFO; tag, result and flags always travel together.

## Test plan
- Reset/empty: assert rst for 2 cycles with in_valid=1.
  - During reset: in_ready=0, out_valid=0, count=0, sticky_o=0, cflags=0, out_result=0.
- Single pass: push result=0x0000_0005, tag=3, flags={0,0,0,0} at edge N.
  - Next cycle: out_valid=1, out_result=5, out_tag=3, count=1.
  - Pop at edge N+1: out_valid=0, count=0, cflags=4'b0000.
- Fill and wrap: push 0xA0..0xA3 with out_ready=0.
  - After the fourth push: count=4, in_ready=0. A fifth push attempt (0xA4) is not accepted.
  - Pop 2, then push 0xB0 and 0xB1. Draining gives A2, A3, B0, B1 in order, confirming pointer wrap.
- Simultaneous push/pop at count=2: in_valid=1 and out_ready=1 for 5 cycles → count stays 2 and the output order is preserved.
- Flags and sticky:
  - Push result=0x8000_0000 with {cout=1,o=1,n=1,z=0}. Sticky_o=1 in the next cycle.
  - After the pop: cflags=4'b1110.
  - Assert clr_sticky alone → sticky_o=0.
  - Assert clr_sticky in the same cycle as a push with o=1 → sticky_o=1.
- Reset mid-stream: with count=3, pulse rst for one cycle → count=0, out_valid=0, in_ready=1 in the following cycle. Old entries never reappear.
